// File: rtl/fgpio_in_cond_if.sv
// Signal bundle between the pad-side conditioning stage and its consumer.
// The slave modport is the conditioning stage; the master drives pads and controls.
interface fgpio_in_cond_if #(
   parameter int unsigned FGPIO_NUM = 8
);
   logic [FGPIO_NUM-1:0] pad_in_i;
   logic [FGPIO_NUM-1:0] gpio_dir_i;
   logic [FGPIO_NUM-1:0] filt_en_i;
   logic [FGPIO_NUM-1:0] edge_clr_i;
   logic [FGPIO_NUM-1:0] gpio_in_val_o;
   logic [FGPIO_NUM-1:0] rise_o;
   logic [FGPIO_NUM-1:0] fall_o;
   logic [FGPIO_NUM-1:0] edge_pend_o;
   logic                 irq_o;

   modport master (
      output pad_in_i, gpio_dir_i, filt_en_i, edge_clr_i,
      input  gpio_in_val_o, rise_o, fall_o, edge_pend_o, irq_o
   );

   modport slave (
      input  pad_in_i, gpio_dir_i, filt_en_i, edge_clr_i,
      output gpio_in_val_o, rise_o, fall_o, edge_pend_o, irq_o
   );
endinterface

// File: rtl/fgpio_in_cond.sv
// Fast-GPIO input conditioning: per-bit synchronizer, optional stable-count
// glitch filter, rise/fall detection and sticky edge flags OR-ed into one irq.
module fgpio_in_cond #(
   parameter int unsigned FGPIO_NUM   = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_CNT    = 4
) (
   input logic           clk_i,
   input logic           rst_ni,
   fgpio_in_cond_if.slave bus
);
   localparam int unsigned CntW = $clog2(FILT_CNT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(FILT_CNT - 1);

   logic [SYNC_STAGES-1:0][FGPIO_NUM-1:0] sync_q;
   logic [FGPIO_NUM-1:0]                  sync_s;
   logic [FGPIO_NUM-1:0]                  stable_q, stable_d;
   logic [FGPIO_NUM-1:0][CntW-1:0]        cnt_q, cnt_d;
   logic [FGPIO_NUM-1:0]                  prev_q;
   logic [FGPIO_NUM-1:0]                  pend_q, pend_d;
   logic [FGPIO_NUM-1:0]                  rise, fall;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // A new level is accepted only after it has differed from stable_q for
   // FILT_CNT consecutive cycles; any return restarts the count.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < int'(FGPIO_NUM); i++) begin
         if (!bus.filt_en_i[i]) begin
            stable_d[i] = sync_s[i];
            cnt_d[i]    = '0;
         end else if (sync_s[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            stable_d[i] = sync_s[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   assign rise   = stable_q & ~prev_q & ~bus.gpio_dir_i;
   assign fall   = ~stable_q & prev_q & ~bus.gpio_dir_i;
   // Set has priority over a clear landing in the same cycle.
   assign pend_d = (pend_q & ~bus.edge_clr_i) | rise | fall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
         prev_q   <= '0;
         pend_q   <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.pad_in_i};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         prev_q   <= stable_q;
         pend_q   <= pend_d;
      end
   end

   assign bus.gpio_in_val_o = stable_q;
   assign bus.rise_o        = rise;
   assign bus.fall_o        = fall;
   assign bus.edge_pend_o   = pend_q;
   assign bus.irq_o         = |pend_q;
endmodule

// File: tb/tb_fgpio_in_cond.sv
// Directed bench for fgpio_in_cond with FGPIO_NUM=8, SYNC_STAGES=2, FILT_CNT=4.
module tb_fgpio_in_cond;
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fgpio_in_cond_if #(.FGPIO_NUM(8)) bus ();

   fgpio_in_cond #(
      .FGPIO_NUM  (8),
      .SYNC_STAGES(2),
      .FILT_CNT   (4)
   ) dut (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance n rising edges; return 1 time unit after the last one.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_val"},  32'(bus.gpio_in_val_o), 32'h0);
      check({tag, "_rise"}, 32'(bus.rise_o),        32'h0);
      check({tag, "_fall"}, 32'(bus.fall_o),        32'h0);
      check({tag, "_pend"}, 32'(bus.edge_pend_o),   32'h0);
      check({tag, "_irq"},  32'(bus.irq_o),         32'h0);
   endtask

   initial begin
      bus.pad_in_i   = 8'hFF;
      bus.gpio_dir_i = 8'h00;
      bus.filt_en_i  = 8'h00;
      bus.edge_clr_i = 8'h00;

      // Reset held with pads high, then released.
      step(3);
      check_all_zero("rst");
      rst_ni = 1'b1;
      step(2);
      check("rel_e2_val", 32'(bus.gpio_in_val_o), 32'h00);
      step(1);
      check("rel_e3_val",  32'(bus.gpio_in_val_o), 32'hFF);
      check("rel_e3_rise", 32'(bus.rise_o),        32'hFF);
      step(1);
      check("rel_e4_pend", 32'(bus.edge_pend_o), 32'hFF);
      check("rel_e4_irq",  32'(bus.irq_o),       32'h1);
      check("rel_e4_rise", 32'(bus.rise_o),      32'h00);
      bus.edge_clr_i = 8'hFF;
      step(1);
      bus.edge_clr_i = 8'h00;
      check("clr_all_pend", 32'(bus.edge_pend_o), 32'h00);
      check("clr_all_irq",  32'(bus.irq_o),       32'h0);

      // Bypass falling edge on bit 0.
      bus.pad_in_i = 8'hFE;
      step(2);
      check("byp_e2_val",  32'(bus.gpio_in_val_o), 32'hFF);
      check("byp_e2_fall", 32'(bus.fall_o),        32'h00);
      step(1);
      check("byp_e3_val",  32'(bus.gpio_in_val_o), 32'hFE);
      check("byp_e3_fall", 32'(bus.fall_o),        32'h01);
      step(1);
      check("byp_e4_fall", 32'(bus.fall_o),      32'h00);
      check("byp_e4_pend", 32'(bus.edge_pend_o), 32'h01);

      // Bring bit 1 low unfiltered, then clear pending.
      bus.pad_in_i = 8'hFC;
      step(4);
      bus.edge_clr_i = 8'hFF;
      step(1);
      bus.edge_clr_i = 8'h00;
      check("pre_glitch_val", 32'(bus.gpio_in_val_o), 32'hFC);

      // Filtered glitch on bit 1: 3 cycles high is rejected.
      bus.filt_en_i = 8'h02;
      bus.pad_in_i  = 8'hFE;
      step(3);
      bus.pad_in_i = 8'hFC;
      step(6);
      check("glitch_val",  32'(bus.gpio_in_val_o), 32'hFC);
      check("glitch_pend", 32'(bus.edge_pend_o),   32'h00);

      // Held high: accepted at edge 6.
      bus.pad_in_i = 8'hFE;
      step(5);
      check("filt_e5_val", 32'(bus.gpio_in_val_o), 32'hFC);
      step(1);
      check("filt_e6_val",  32'(bus.gpio_in_val_o), 32'hFE);
      check("filt_e6_rise", 32'(bus.rise_o),        32'h02);
      step(1);
      check("filt_e7_pend", 32'(bus.edge_pend_o), 32'h02);
      bus.edge_clr_i = 8'h02;
      step(1);
      bus.edge_clr_i = 8'h00;

      // Set wins over clear on bit 0, then a lone clear drops it.
      bus.pad_in_i = 8'hFF;
      step(3);
      check("sc_rise", 32'(bus.rise_o), 32'h01);
      bus.edge_clr_i = 8'h01;
      step(1);
      check("sc_set_wins", 32'(bus.edge_pend_o), 32'h01);
      step(1);
      bus.edge_clr_i = 8'h00;
      check("sc_clr_pend", 32'(bus.edge_pend_o), 32'h00);
      check("sc_clr_irq",  32'(bus.irq_o),       32'h0);

      // Output-direction bit 2: level follows, no edges reported.
      bus.gpio_dir_i = 8'h04;
      bus.pad_in_i   = 8'hFB;
      step(3);
      check("dir_fall_val", 32'(bus.gpio_in_val_o), 32'hFB);
      check("dir_fall",     32'(bus.fall_o),        32'h00);
      step(1);
      check("dir_fall_pend", 32'(bus.edge_pend_o), 32'h00);
      bus.pad_in_i = 8'hFF;
      step(3);
      check("dir_rise_val", 32'(bus.gpio_in_val_o), 32'hFF);
      check("dir_rise",     32'(bus.rise_o),        32'h00);
      step(1);
      check("dir_rise_pend", 32'(bus.edge_pend_o), 32'h00);
      check("dir_rise_irq",  32'(bus.irq_o),       32'h0);

      // Reset in the middle of a filter count on bit 3.
      bus.gpio_dir_i = 8'h00;
      bus.filt_en_i  = 8'h0A;
      bus.pad_in_i   = 8'hF7;
      step(7);
      check("pre_rst_val", 32'(bus.gpio_in_val_o), 32'hF7);
      bus.edge_clr_i = 8'hFF;
      step(1);
      bus.edge_clr_i = 8'h00;
      bus.pad_in_i   = 8'hFF;
      step(4);
      check("midcnt_val", 32'(bus.gpio_in_val_o), 32'hF7);
      rst_ni = 1'b0;
      #1;
      check_all_zero("midrst");
      step(1);
      rst_ni = 1'b1;
      step(3);
      check("rel2_e3_val",  32'(bus.gpio_in_val_o), 32'hF5);
      check("rel2_e3_rise", 32'(bus.rise_o),        32'hF5);
      step(2);
      check("rel2_e5_val", 32'(bus.gpio_in_val_o), 32'hF5);
      step(1);
      check("rel2_e6_val",  32'(bus.gpio_in_val_o), 32'hFF);
      check("rel2_e6_rise", 32'(bus.rise_o),        32'h0A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fgpio_in_cond.md
Name: fgpio_in_cond

Overview:
Input conditioning stage directly upstream of the fast-GPIO instruction unit. It takes raw asynchronous pad inputs and drives that unit's gpio_in_val input. Per bit it provides a synchronizer, an optional stable-count glitch filter, and rise/fall edge detection. Sticky edge-pending flags are OR-ed into one interrupt line.

Parameters:
FGPIO_NUM, DRCP_PKG::FGPIO_NUM, number of GPIO bits (1..32)
SYNC_STAGES, 2, synchronizer flop depth (>=2)
FILT_CNT, 4, consecutive cycles a new level must hold before acceptance when filtering (>=1)

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
pad_in_i  input  FGPIO_NUM  raw asynchronous pad levels
gpio_dir_i  input  FGPIO_NUM  direction from the fast-GPIO unit; 1 = output, 0 = input
filt_en_i  input  FGPIO_NUM  per-bit filter enable; 0 = bypass
edge_clr_i  input  FGPIO_NUM  write-1-to-clear for edge_pend_o
gpio_in_val_o  output  FGPIO_NUM  conditioned level; connects to the fast-GPIO unit's gpio_in_val
rise_o  output  FGPIO_NUM  one-cycle rising-edge pulse
fall_o  output  FGPIO_NUM  one-cycle falling-edge pulse
edge_pend_o  output  FGPIO_NUM  sticky edge-seen flags
irq_o  output  1  OR of edge_pend_o

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset: every flop clears to 0, including sync chain, counters, stable_q, prev_q and pend. All outputs read 0 while rst_ni is low.
- Synchronizer: SYNC_STAGES-flop chain per bit; sync_s is the last stage.
- Filter state per bit: stable_q, plus cnt of width $clog2(FILT_CNT+1).
- Filter bypassed (filt_en_i=0): stable_q <= sync_s every cycle; cnt <= 0.
- Filter enabled, sync_s == stable_q: cnt <= 0.
- Filter enabled, sync_s != stable_q and cnt == FILT_CNT-1: stable_q <= sync_s; cnt <= 0.
- Filter enabled, sync_s != stable_q otherwise: cnt <= cnt+1.
- Any return of sync_s to stable_q before acceptance restarts the count.
- filt_en_i deasserted mid-count: cnt zeroes and stable_q follows sync_s next edge.
- gpio_in_val_o = stable_q, always, independent of direction.
- Latency from pad change to gpio_in_val_o: SYNC_STAGES+1 edges when bypassed; SYNC_STAGES+FILT_CNT edges when filtered.
- Edge detect: prev_q <= stable_q each cycle.
- rise_o = stable_q & ~prev_q & ~gpio_dir_i.
- fall_o = ~stable_q & prev_q & ~gpio_dir_i.
- Edge pulses are coincident with the first cycle of the new gpio_in_val_o level.
- Output-direction bits: gpio_dir_i=1 suppresses rise/fall/pend for that bit. Its level is still reported.
- Pending: pend <= (pend & ~edge_clr_i) | rise_o | fall_o.
  - Set wins over a simultaneous clear.
  - edge_pend_o rises one cycle after the pulse.
- irq_o = |pend, combinational from flops only.
- After reset release with a pad held high: treated as a rising edge once latency elapses; no special suppression.
- Direction change mid-pulse: gating is purely combinational on the current gpio_dir_i.

Test Plan:
(FGPIO_NUM=8, SYNC_STAGES=2, FILT_CNT=4)
1. Reset: rst_ni=0, pad_in_i=0xFF, toggle clock -> all outputs 0. Release rst_ni, filt_en_i=0 -> gpio_in_val_o=0xFF and rise_o=0xFF at edge 3; edge_pend_o=0xFF and irq_o=1 at edge 4.
2. Bypass edges: filt_en_i=0, pad bit0 1->0 -> fall_o[0] one-cycle pulse at edge 3; gpio_in_val_o[0]=0 same cycle; edge_pend_o[0]=1 at edge 4.
3. Glitch: filt_en_i[1]=1, pad bit1 high for 3 cycles then low -> gpio_in_val_o[1] stays 0, no pulse. Pad held high 4+ cycles -> gpio_in_val_o[1]=1 and rise_o[1] at edge 6.
4. Clear vs set: edge_clr_i[0]=1 in the rise_o[0] cycle -> edge_pend_o[0] stays 1. Later edge_clr_i[0]=1 alone -> 0 next cycle; irq_o=0 when all clear.
5. Direction gating: gpio_dir_i[2]=1, toggle pad bit2 -> gpio_in_val_o[2] follows; rise_o[2]/fall_o[2]/edge_pend_o[2] remain 0.
6. Reset mid-filter: filt_en_i[3]=1, pad bit3 high 2 cycles (cnt=2), assert rst_ni -> cnt/outputs 0 immediately. Release with pad high -> rise_o[3] at edge 6 after release.
